// File: rtl/mode_select_commit.sv
// mode_select_commit: debounce-and-commit of the priority-encoded button press.
// Qualifies a stable press, hands it to the pattern engine over req/ack and
// waits for a stable release before accepting the next press.
// Ports: clk, rst (async, high) | code[2:0], z from encoder (async to clk)
//        req, req_mode[2:0] / ack handshake to pattern engine
//        mode[2:0] committed mode, commit_count[7:0], state[1:0] debug
module mode_select_commit #(
  parameter int         STABLE_CYCLES = 4,
  parameter logic [2:0] DEFAULT_MODE  = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       z,
  output logic       req,
  output logic [2:0] req_mode,
  input  logic       ack,
  output logic [2:0] mode,
  output logic [7:0] commit_count,
  output logic [1:0] state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]    cand, cand_n;
  logic          req_n;
  logic [2:0]    req_mode_n;
  logic [2:0]    mode_n;
  logic [7:0]    count_n;

  // {z, code}; idle value is "no button"
  logic [3:0] s1, s2;
  logic       z_s;
  logic [2:0] code_s;

  assign z_s    = s2[3];
  assign code_s = s2[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 4'b1000;
      s2 <= 4'b1000;
    end else begin
      s1 <= {z, code};
      s2 <= s1;
    end
  end

  // saturating increment
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + ONE;

  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    cand_n     = cand;
    req_n      = req;
    req_mode_n = req_mode;
    mode_n     = mode;
    count_n    = commit_count;
    unique case (st)
      IDLE: begin
        if (!z_s) begin
          cand_n = code_s;
          cnt_n  = ONE;
          st_n   = QUALIFY;
        end
      end
      QUALIFY: begin
        if (z_s) begin
          cnt_n = '0;
          st_n  = IDLE;
        end else if (code_s != cand) begin
          cand_n = code_s;
          cnt_n  = ONE;
        end else if (cnt_inc == CMAX) begin
          cnt_n = '0;
          if (cand == mode) begin
            st_n = RELEASE;
          end else begin
            req_n      = 1'b1;
            req_mode_n = cand;
            st_n       = REQ;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      REQ: begin
        // inputs ignored so a qualified press is never dropped
        if (ack) begin
          mode_n  = req_mode;
          req_n   = 1'b0;
          count_n = commit_count + 8'd1;
          cnt_n   = '0;
          st_n    = RELEASE;
        end
      end
      RELEASE: begin
        if (!z_s) begin
          cnt_n = '0;
        end else if (cnt_inc == CMAX) begin
          cnt_n = '0;
          st_n  = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      cnt          <= '0;
      cand         <= 3'd0;
      req          <= 1'b0;
      req_mode     <= 3'd0;
      mode         <= DEFAULT_MODE;
      commit_count <= 8'd0;
    end else begin
      st           <= st_n;
      cnt          <= cnt_n;
      cand         <= cand_n;
      req          <= req_n;
      req_mode     <= req_mode_n;
      mode         <= mode_n;
      commit_count <= count_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mode_select_commit.sv
// tb_mode_select_commit: randomized and directed bench for mode_select_commit
// against a run-length behavioural model of the press/commit/release rules.
module tb_mode_select_commit;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code = 3'd0;
  logic       z = 1'b1;
  logic       ack = 1'b0;
  logic       req;
  logic [2:0] req_mode;
  logic [2:0] mode;
  logic [7:0] commit_count;
  logic [1:0] state;

  int vec = 0;
  int err = 0;

  mode_select_commit #(.STABLE_CYCLES(N), .DEFAULT_MODE(3'd0)) dut (
    .clk(clk), .rst(rst), .code(code), .z(z),
    .req(req), .req_mode(req_mode), .ack(ack),
    .mode(mode), .commit_count(commit_count), .state(state)
  );

  always #5 clk = ~clk;

  // model: phase 0 accepting presses, 1 awaiting ack, 2 awaiting release
  int pz0, pz1, pc0, pc1;
  int phase, run, lastc, rrun;
  int m_req, m_rmode, m_mode, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pz0 = 1; pz1 = 1; pc0 = 0; pc1 = 0;
      phase = 0; run = 0; lastc = 0; rrun = 0;
      m_req = 0; m_rmode = 0; m_mode = 0; m_cnt = 0;
    end else begin
      int cz, cc;
      cz = pz1; cc = pc1;
      pz1 = pz0; pc1 = pc0;
      pz0 = int'(z); pc0 = int'(code);
      if (phase == 0) begin
        if (cz == 1) run = 0;
        else if (run > 0 && cc == lastc) run++;
        else begin run = 1; lastc = cc; end
        if (run == N) begin
          run = 0;
          if (lastc == m_mode) begin phase = 2; rrun = 0; end
          else begin m_req = 1; m_rmode = lastc; phase = 1; end
        end
      end else if (phase == 1) begin
        if (ack) begin
          m_mode = m_rmode; m_req = 0;
          m_cnt = (m_cnt + 1) % 256;
          phase = 2; rrun = 0;
        end
      end else begin
        rrun = (cz == 1) ? rrun + 1 : 0;
        if (rrun == N) begin phase = 0; run = 0; end
      end
    end
  end

  function automatic logic [16:0] exp_vec();
    logic [1:0] s;
    if (phase == 0) s = (run > 0) ? 2'd1 : 2'd0;
    else if (phase == 1) s = 2'd2;
    else s = 2'd3;
    return {1'(m_req), 3'(m_rmode), 3'(m_mode), 8'(m_cnt), s};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {req, req_mode, mode, commit_count, state};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    code = 3'd5; z = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      cyc();
      vec++;
      if (dut_vec() !== exp_vec()) begin
        err++;
        $display("FAIL reset_press got %h want %h", dut_vec(), exp_vec());
      end
      if (e < 5) begin
        vec++;
        if (req !== 1'b0) begin
          err++;
          $display("FAIL early_req edge %0d got %b want 0", e, req);
        end
      end
    end
    vec++;
    if ({req, req_mode} !== {1'b1, 3'd5}) begin
      err++;
      $display("FAIL req_edge5 got %b/%0d want 1/5", req, req_mode);
    end
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    vec++;
    if ({mode, req, commit_count} !== {3'd5, 1'b0, 8'd1}) begin
      err++;
      $display("FAIL commit_edge7 got m%0d r%b c%0d want m5 r0 c1",
               mode, req, commit_count);
    end
    #3 rst = 1'b1;
    #1;
    vec++;
    if (dut_vec() !== 17'd0) begin
      err++;
      $display("FAIL async_reset got %h want 0", dut_vec());
    end
    @(negedge clk);
    z = 1'b1; code = 3'd0;
    rst = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_bounce();
    code = 3'd1; z = 1'b0;
    repeat (3) cyc();
    z = 1'b1;
    cyc();
    z = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      cyc();
      vec++;
      if (dut_vec() !== exp_vec() || (e < 5 && req !== 1'b0)) begin
        err++;
        $display("FAIL bounce edge %0d got %h want %h", e, dut_vec(), exp_vec());
      end
    end
    vec++;
    if ({req, req_mode} !== {1'b1, 3'd1}) begin
      err++;
      $display("FAIL bounce_req got %b/%0d want 1/1", req, req_mode);
    end
    ack = 1'b1; cyc(); ack = 1'b0;
    z = 1'b1;
    repeat (8) cyc();
    code = 3'd5; z = 1'b0;
    repeat (2) cyc();
    code = 3'd6;
    for (int i = 0; i < 8; i++) begin
      cyc();
      vec++;
      if (dut_vec() !== exp_vec()) begin
        err++;
        $display("FAIL code_change got %h want %h", dut_vec(), exp_vec());
      end
    end
    vec++;
    if ({req, req_mode} !== {1'b1, 3'd6}) begin
      err++;
      $display("FAIL restart_req got %b/%0d want 1/6", req, req_mode);
    end
    ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  task automatic test_same_mode();
    z = 1'b1;
    repeat (8) cyc();
    code = 3'd6; z = 1'b0;
    repeat (10) cyc();
    vec++;
    if ({req, state, mode} !== {1'b0, 2'd3, 3'd6}) begin
      err++;
      $display("FAIL same_mode got r%b s%0d m%0d want r0 s3 m6",
               req, state, mode);
    end
    z = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      cyc();
      vec++;
      if (dut_vec() !== exp_vec()) begin
        err++;
        $display("FAIL release got %h want %h", dut_vec(), exp_vec());
      end
      if (e == 4 || e == 5) begin
        vec++;
        if (state !== ((e == 4) ? 2'd3 : 2'd0)) begin
          err++;
          $display("FAIL release_edge%0d got %0d want %0d",
                   e, state, (e == 4) ? 3 : 0);
        end
      end
    end
  endtask

  task automatic test_handshake();
    code = 3'd2; z = 1'b0;
    for (int i = 0; i < 30 && req !== 1'b1; i++) cyc();
    vec++;
    if (req !== 1'b1) begin
      err++;
      $display("FAIL hs_timeout got req %b want 1", req);
    end
    for (int i = 0; i < 20; i++) begin
      z = 1'($urandom_range(0, 1));
      code = 3'($urandom_range(0, 7));
      cyc();
      vec++;
      if ({req, req_mode} !== {1'b1, 3'd2} || dut_vec() !== exp_vec()) begin
        err++;
        $display("FAIL hs_hold got %h want %h", dut_vec(), exp_vec());
      end
    end
    ack = 1'b1; cyc(); ack = 1'b0;
    vec++;
    if ({mode, req} !== {3'd2, 1'b0}) begin
      err++;
      $display("FAIL hs_commit got m%0d r%b want m2 r0", mode, req);
    end
    z = 1'b1;
    repeat (10) cyc();
    ack = 1'b1;
    repeat (3) cyc();
    ack = 1'b0;
    vec++;
    if ({mode, state, commit_count} !== {3'd2, 2'd0, 8'(m_cnt)}) begin
      err++;
      $display("FAIL stray_ack got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_release_gating();
    code = 3'd3; z = 1'b0;
    for (int i = 0; i < 30 && req !== 1'b1; i++) cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      vec++;
      if ({req, state} !== {1'b0, 2'd3} || dut_vec() !== exp_vec()) begin
        err++;
        $display("FAIL gating got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int c0;
    logic [2:0] c;
    c0 = m_cnt;
    for (int k = 0; k < 256; k++) begin
      z = 1'b1;
      repeat (N + 3) cyc();
      c = (m_mode == 7) ? 3'd0 : 3'd7;
      code = c; z = 1'b0;
      for (int i = 0; i < 20 && req !== 1'b1; i++) cyc();
      ack = 1'b1; cyc(); ack = 1'b0;
      if (mode !== c || dut_vec() !== exp_vec()) begin
        vec++; err++;
        $display("FAIL wrap_commit %0d got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    vec++;
    if (commit_count !== 8'(c0)) begin
      err++;
      $display("FAIL wrap got %0d want %0d", commit_count, c0);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 8);
        z = 1'($urandom_range(0, 1));
        code = 3'($urandom_range(0, 7));
      end
      hold--;
      ack = ($urandom_range(0, 3) == 0);
      cyc();
      vec++;
      if (dut_vec() !== exp_vec()) begin
        err++;
        $display("FAIL random %0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    z = 1'b1;
    repeat (12) cyc();
    code = (m_mode == 4) ? 3'd1 : 3'd4; z = 1'b0;
    for (int i = 0; i < 30 && req !== 1'b1; i++) cyc();
    vec++;
    if (req !== 1'b1) begin
      err++;
      $display("FAIL mid_req_timeout got %b want 1", req);
    end
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({req, mode, state, commit_count} !== {1'b0, 3'd0, 2'd0, 8'd0}) begin
      err++;
      $display("FAIL mid_req_reset got %h want 0", dut_vec());
    end
    @(negedge clk);
    z = 1'b1;
    rst = 1'b0;
    repeat (4) cyc();
    code = 3'd3; z = 1'b0;
    for (int i = 0; i < 30 && req !== 1'b1; i++) cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    vec++;
    if ({mode, commit_count} !== {3'd3, 8'd1} || dut_vec() !== exp_vec()) begin
      err++;
      $display("FAIL resume got m%0d c%0d want m3 c1", mode, commit_count);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_bounce();
    test_same_mode();
    test_handshake();
    test_release_gating();
    test_wrap();
    test_random();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
